// File: rtl/conv_pixel_writeback.sv
// conv_pixel_writeback
// Packs filtered 8-bit pixels from the convolution coprocessor into 32-bit
// VGA-memory words and writes each word when the memory arbiter grants the port.
//
// Ports:
//   clk, reset_n           clock and asynchronous active-low reset
//   pix_valid/pix_ready    pixel handshake; pix_data, pix_h, pix_v are the pixel and its coordinate
//   flush                  single-cycle request to write the partially filled word now
//   mem_grant              arbiter grant (low while the camera owns the memory)
//   mem_we/addr/data       single-cycle write to VGA memory, addr = {v, h[8:2]}
//   frame_done             one-cycle pulse after the word holding (H_MAX,V_MAX) is written
//   busy                   a word is held, a write is pending, or a pixel is parked
module conv_pixel_writeback #(
    parameter int H_MAX  = 511,
    parameter int V_MAX  = 479,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic [8:0]        pix_h,
    input  logic [8:0]        pix_v,
    output logic              pix_ready,
    input  logic              flush,
    input  logic              mem_grant,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              frame_done,
    output logic              busy
);

    typedef enum logic {
        COLLECT,
        WRITE
    } state_t;

    localparam logic [8:0] H_LAST = 9'(H_MAX);
    localparam logic [8:0] V_LAST = 9'(V_MAX);

    state_t              state;
    logic [31:0]         word;
    logic [3:0]          lane_mask;
    logic [ADDR_W-1:0]   word_addr;
    logic                word_has_last;
    logic                frame_done_q;

    logic                pend_full;
    logic [PIX_W-1:0]    pend_data;
    logic [8:0]          pend_h;
    logic [8:0]          pend_v;

    logic                accept;
    logic [ADDR_W-1:0]   pix_addr;
    logic [1:0]          pix_lane;
    logic [4:0]          pix_off;
    logic                same_word;
    logic                pix_closes;
    logic                pix_is_last;
    logic [ADDR_W-1:0]   pend_addr;
    logic [1:0]          pend_lane;
    logic [4:0]          pend_off;
    logic                pend_closes;
    logic                pend_is_last;

    // Decode of the incoming pixel and of the parked pixel. A word is closed
    // early by its last lane or by the last column of a row, because the next
    // pixel can never land in the same word in either case.
    assign accept       = pix_valid & pix_ready;
    assign pix_addr     = ADDR_W'({pix_v, pix_h[8:2]});
    assign pix_lane     = pix_h[1:0];
    assign pix_off      = 5'(32'(pix_lane) * PIX_W);
    assign same_word    = (lane_mask == 4'd0) || (pix_addr == word_addr);
    assign pix_closes   = (pix_lane == 2'd3) || (pix_h == H_LAST);
    assign pix_is_last  = (pix_h == H_LAST) && (pix_v == V_LAST);

    assign pend_addr    = ADDR_W'({pend_v, pend_h[8:2]});
    assign pend_lane    = pend_h[1:0];
    assign pend_off     = 5'(32'(pend_lane) * PIX_W);
    assign pend_closes  = (pend_lane == 2'd3) || (pend_h == H_LAST);
    assign pend_is_last = (pend_h == H_LAST) && (pend_v == V_LAST);

    // Main collector/writer. In COLLECT pixels are merged into the word; a
    // pixel for a different word is parked so the handshake never has to
    // stall mid-transfer. In WRITE the word is held until granted; the parked
    // pixel then seeds the next word and may immediately close it again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= COLLECT;
            word          <= '0;
            lane_mask     <= '0;
            word_addr     <= '0;
            word_has_last <= 1'b0;
            frame_done_q  <= 1'b0;
            pend_full     <= 1'b0;
            pend_data     <= '0;
            pend_h        <= '0;
            pend_v        <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        if (same_word) begin
                            if (lane_mask == 4'd0) begin
                                word_addr <= pix_addr;
                            end
                            word[pix_off +: PIX_W] <= pix_data;
                            lane_mask[pix_lane]    <= 1'b1;
                            if (pix_is_last) begin
                                word_has_last <= 1'b1;
                            end
                            if (pix_closes || flush) begin
                                state <= WRITE;
                            end
                        end else begin
                            pend_full <= 1'b1;
                            pend_data <= pix_data;
                            pend_h    <= pix_h;
                            pend_v    <= pix_v;
                            state     <= WRITE;
                        end
                    end else if (flush && (lane_mask != 4'd0)) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_grant) begin
                        frame_done_q <= word_has_last;
                        if (pend_full) begin
                            word                    <= '0;
                            word[pend_off +: PIX_W] <= pend_data;
                            lane_mask               <= 4'b0001 << pend_lane;
                            word_addr               <= pend_addr;
                            word_has_last           <= pend_is_last;
                            pend_full               <= 1'b0;
                            state                   <= pend_closes ? WRITE : COLLECT;
                        end else begin
                            word          <= '0;
                            lane_mask     <= '0;
                            word_has_last <= 1'b0;
                            state         <= COLLECT;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Outputs are direct decodes of registered state; the write strobe follows
    // the grant combinationally so a granted cycle is never wasted.
    assign pix_ready  = (state == COLLECT) && !pend_full;
    assign mem_we     = (state == WRITE) && mem_grant;
    assign mem_addr   = word_addr;
    assign mem_data   = word;
    assign frame_done = frame_done_q;
    assign busy       = (lane_mask != 4'd0) || (state == WRITE) || pend_full;

endmodule

// File: tb/tb_conv_pixel_writeback.sv
// tb_conv_pixel_writeback
// Directed and randomized checks of conv_pixel_writeback against a reference
// model that turns the accepted pixel stream into the list of expected memory
// writes (address, packed data, end-of-frame flag).
module tb_conv_pixel_writeback;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic [8:0]  pix_h;
    logic [8:0]  pix_v;
    logic        pix_ready;
    logic        flush;
    logic        mem_grant;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_data;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit randGrant = 1'b0;
    bit expFd = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t        expQ[$];
    logic [7:0] mLane[4];
    logic [3:0] mMask;
    logic [15:0] mAddr;
    bit         mLast;

    conv_pixel_writeback dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_h      (pix_h),
        .pix_v      (pix_v),
        .pix_ready  (pix_ready),
        .flush      (flush),
        .mem_grant  (mem_grant),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: a word buffer expressed as four byte slots.
    task automatic modelClear();
        for (int i = 0; i < 4; i++) mLane[i] = 8'h00;
        mMask = 4'd0;
        mLast = 1'b0;
    endtask

    task automatic modelPush();
        wr_t e;
        e.addr = mAddr;
        e.data = {mLane[3], mLane[2], mLane[1], mLane[0]};
        e.last = mLast;
        expQ.push_back(e);
        modelClear();
    endtask

    task automatic modelPixel(input logic [7:0] d, input logic [8:0] h, input logic [8:0] v, input logic fl);
        logic [15:0] a;
        int lane;
        bit closes;
        a = {v, h[8:2]};
        lane = int'(h[1:0]);
        closes = (lane == 3) || (h == 9'd511);
        if (mMask != 4'd0 && a != mAddr) begin
            modelPush();
            fl = 1'b0;
        end
        if (mMask == 4'd0) mAddr = a;
        mLane[lane] = d;
        mMask[lane] = 1'b1;
        if (h == 9'd511 && v == 9'd479) mLast = 1'b1;
        if (closes || fl) modelPush();
    endtask

    task automatic modelFlush();
        if (mMask != 4'd0) modelPush();
    endtask

    // Present one pixel and hold it until it is accepted (bounded wait).
    task automatic applyStimulus(input logic [7:0] d, input logic [8:0] h, input logic [8:0] v, input logic fl);
        int waitCycles = 0;
        bit done = 1'b0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_h     = h;
        pix_v     = v;
        flush     = fl;
        while (!done) begin
            @(negedge clk);
            if (pix_ready) begin
                @(posedge clk);
                modelPixel(d, h, v, fl);
                done = 1'b1;
            end else begin
                waitCycles++;
                if (waitCycles > 200) begin
                    checkOutput("accept_timeout", 32'(pix_ready), 32'd1);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                end
            end
            #1;
            if (randGrant) mem_grant = 1'($urandom_range(0, 1));
        end
        pix_valid = 1'b0;
        flush     = 1'b0;
    endtask

    // Pulse flush for one cycle once the block is collecting.
    task automatic applyFlush();
        int waitCycles = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (pix_ready) begin
                flush = 1'b1;
                @(posedge clk);
                modelFlush();
                done = 1'b1;
            end else begin
                waitCycles++;
                if (waitCycles > 200) begin
                    checkOutput("flush_timeout", 32'(pix_ready), 32'd1);
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                end
            end
            #1;
            flush = 1'b0;
            if (randGrant) mem_grant = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (randGrant) mem_grant = 1'($urandom_range(0, 1));
        end
    endtask

    // Write monitor: every strobe must match the next expected write, and
    // frame_done must pulse exactly in the cycle after an end-of-frame write.
    always @(negedge clk) begin
        if (!reset_n) begin
            expFd = 1'b0;
        end else begin
            checkOutput("frame_done", 32'(frame_done), 32'(expFd));
            expFd = 1'b0;
            if (mem_we) begin
                checkOutput("mem_we_expected", 32'(mem_we), 32'(expQ.size() != 0));
                if (expQ.size() != 0) begin
                    wr_t e;
                    e = expQ.pop_front();
                    checkOutput("write_addr", 32'(mem_addr), 32'(e.addr));
                    checkOutput("write_data", mem_data, e.data);
                    expFd = e.last;
                end
            end
        end
    end

    initial begin
        logic [8:0] ch;
        logic [8:0] cv;

        modelClear();
        mAddr     = 16'h0000;
        reset_n   = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        pix_h     = 9'd0;
        pix_v     = 9'd0;
        flush     = 1'b0;
        mem_grant = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pix_ready", 32'(pix_ready), 32'd1);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_data", mem_data, 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Four lanes back to back.
        applyStimulus(8'h11, 9'd0, 9'd0, 1'b0);
        applyStimulus(8'h22, 9'd1, 9'd0, 1'b0);
        applyStimulus(8'h33, 9'd2, 9'd0, 1'b0);
        applyStimulus(8'h44, 9'd3, 9'd0, 1'b0);
        @(negedge clk);
        checkOutput("t1_we", 32'(mem_we), 32'd1);
        checkOutput("t1_addr", 32'(mem_addr), 32'h0000);
        checkOutput("t1_data", mem_data, 32'h44332211);
        checkOutput("t1_ready_low", 32'(pix_ready), 32'd0);
        @(negedge clk);
        checkOutput("t1_ready_back", 32'(pix_ready), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // End of row, then start of the next row.
        for (int i = 0; i < 4; i++) applyStimulus(8'hA0 + 8'(i), 9'(508 + i), 9'd5, 1'b0);
        @(negedge clk);
        checkOutput("t2_addr", 32'(mem_addr), 32'h02FF);
        checkOutput("t2_data", mem_data, 32'hA3A2A1A0);
        @(posedge clk);
        #1;
        applyStimulus(8'h5C, 9'd0, 9'd6, 1'b0);
        applyFlush();
        @(negedge clk);
        checkOutput("t2_next_we", 32'(mem_we), 32'd1);
        checkOutput("t2_next_addr", 32'(mem_addr), 32'h0300);
        checkOutput("t2_next_data", mem_data, 32'h0000005C);
        @(posedge clk);
        #1;

        // Address change parks the new pixel.
        applyStimulus(8'h01, 9'd4, 9'd0, 1'b0);
        applyStimulus(8'h02, 9'd5, 9'd0, 1'b0);
        applyStimulus(8'h03, 9'd12, 9'd0, 1'b0);
        @(negedge clk);
        checkOutput("t3_addr", 32'(mem_addr), 32'h0001);
        checkOutput("t3_data", mem_data, 32'h00000201);
        @(negedge clk);
        checkOutput("t3_busy_held", 32'(busy), 32'd1);
        #1;
        applyFlush();
        @(negedge clk);
        checkOutput("t3_pend_addr", 32'(mem_addr), 32'h0003);
        checkOutput("t3_pend_data", mem_data, 32'h00000003);
        @(posedge clk);
        #1;

        // Duplicate lane: last value wins.
        applyStimulus(8'h55, 9'd8, 9'd1, 1'b0);
        applyStimulus(8'h66, 9'd8, 9'd1, 1'b0);
        applyStimulus(8'h77, 9'd9, 9'd1, 1'b0);
        applyStimulus(8'h88, 9'd10, 9'd1, 1'b0);
        applyStimulus(8'h99, 9'd11, 9'd1, 1'b0);
        @(negedge clk);
        checkOutput("t_dup_addr", 32'(mem_addr), 32'h0082);
        checkOutput("t_dup_data", mem_data, 32'h99887766);
        @(posedge clk);
        #1;

        // Grant withheld for ten cycles.
        mem_grant = 1'b0;
        applyStimulus(8'hAA, 9'd16, 9'd2, 1'b0);
        applyStimulus(8'hBB, 9'd17, 9'd2, 1'b0);
        applyStimulus(8'hCC, 9'd18, 9'd2, 1'b0);
        applyStimulus(8'hDD, 9'd19, 9'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t4_we_low", 32'(mem_we), 32'd0);
            checkOutput("t4_ready_low", 32'(pix_ready), 32'd0);
            checkOutput("t4_addr_hold", 32'(mem_addr), 32'h0104);
            checkOutput("t4_data_hold", mem_data, 32'hDDCCBBAA);
        end
        @(posedge clk);
        #1;
        mem_grant = 1'b1;
        @(negedge clk);
        checkOutput("t4_we_granted", 32'(mem_we), 32'd1);
        @(negedge clk);
        checkOutput("t4_ready_back", 32'(pix_ready), 32'd1);
        #1;

        // Last word of the frame.
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 9'(508 + i), 9'd479, 1'b0);
        @(negedge clk);
        checkOutput("t5_addr", 32'(mem_addr), 32'hEFFF);
        @(negedge clk);
        checkOutput("t5_frame_done", 32'(frame_done), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("t5_frame_done_once", 32'(frame_done), 32'd0);
        #1;

        // Asynchronous reset while a write is stalled.
        mem_grant = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 9'(20 + i), 9'd3, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        expQ.delete();
        modelClear();
        checkOutput("t6_we", 32'(mem_we), 32'd0);
        checkOutput("t6_addr", 32'(mem_addr), 32'd0);
        checkOutput("t6_data", mem_data, 32'd0);
        checkOutput("t6_ready", 32'(pix_ready), 32'd1);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mem_grant = 1'b1;
        idle(5);
        checkOutput("t6_busy_after", 32'(busy), 32'd0);

        // Randomized raster with jumps, flushes and a toggling grant.
        randGrant = 1'b1;
        ch = 9'($urandom_range(0, 511));
        cv = 9'($urandom_range(0, 479));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ch = 9'($urandom_range(0, 511));
                cv = 9'($urandom_range(0, 511));
            end else if (ch == 9'd511) begin
                ch = 9'd0;
                cv = (cv >= 9'd479) ? 9'd0 : cv + 9'd1;
            end else begin
                ch = ch + 9'd1;
            end
            applyStimulus(8'($urandom), ch, cv, 1'($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 19) == 0) applyFlush();
            if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 4)));
        end

        // Drain.
        randGrant = 1'b0;
        mem_grant = 1'b1;
        applyFlush();
        idle(6);
        checkOutput("drain_queue", 32'(expQ.size()), 32'd0);
        checkOutput("drain_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_pixel_writeback.md
Name: conv_pixel_writeback

Overview:
- Downstream stage of the convolution IPU. It consumes the 8-bit filtered pixels that the coprocessor produces after each completed convolution, one pixel per handshake, tagged with that pixel's (h,v) coordinate.
- It packs four consecutive pixels into one 32-bit VGA-memory word and issues a single-cycle write when the memory port is granted.
- It replaces the per-pixel write path into vgaMemory and signals end of frame to the IPU sequencer.

Parameters:
- H_MAX, 511: last column index of a frame row.
- V_MAX, 479: last row index of a frame.
- PIX_W, 8: pixel width in bits.
- ADDR_W, 16: memory word-address width; address = {v[8:0], h[8:2]}.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- pix_valid  input  1  a filtered pixel is presented.
- pix_data  input  PIX_W  filtered pixel value.
- pix_h  input  9  column of the pixel.
- pix_v  input  9  row of the pixel.
- pix_ready  output  1  block can accept a pixel this cycle.
- flush  input  1  single-cycle request to write the partial word immediately.
- mem_grant  input  1  arbiter grants the memory port (low while the camera writes).
- mem_we  output  1  write strobe to VGA memory.
- mem_addr  output  ADDR_W  word address.
- mem_data  output  32  packed word.
- frame_done  output  1  one-cycle pulse after the word holding (H_MAX,V_MAX) is written.
- busy  output  1  a word is held or a write is pending.

Behaviour:
- One clock domain. Reset is asynchronous, active-low (reset_n), and applies in any state.
- Reset values: state COLLECT; word=0; lane_mask=0; pending empty; pix_ready=1; mem_we=0; mem_addr=0; mem_data=0; frame_done=0; busy=0.
- Handshake: a pixel is accepted on a rising edge where pix_valid & pix_ready are both high. pix_ready=1 only in COLLECT with the pending register empty.
- Lane mapping: lane = pix_h[1:0]. Lane 0 = bits 7:0, lane 3 = bits 31:24. Lanes not written in a word are 0.
- Word address = {pix_v, pix_h[8:2]}. It is latched on the first pixel accepted into an empty word.
- States:
  - COLLECT:
    - Accept with word empty, or with same word address: write the lane and set its lane_mask bit.
    - Go to WRITE if lane==3, or if pix_h==H_MAX, or if flush is high in the same cycle.
    - Accept with a different word address while the word is non-empty: the old word is untouched; the new pixel goes into the pending register (value, h, v); go to WRITE.
    - flush with word non-empty and no accept: go to WRITE. flush with word empty: ignored.
  - WRITE:
    - mem_we = mem_grant (combinational); mem_addr and mem_data are stable for the whole of WRITE.
    - On an edge with mem_grant=1 the write completes. Clear word and lane_mask. If pending is full, load it as the first pixel of the new word (applying the same lane==3 / H_MAX rules, which may re-enter WRITE) and empty pending. Go to COLLECT.
    - If the written word contained (H_MAX,V_MAX), pulse frame_done on the next cycle.
    - mem_grant=0: hold all outputs and stay in WRITE indefinitely.
- Latency: lane-3 pixel accepted at edge N -> mem_we high during cycle N+1 if granted. The block returns to COLLECT with pix_ready=1 after edge N+1.
- A duplicate lane within the same word overwrites the lane (last value wins), with no early flush.
- Coordinates beyond H_MAX/V_MAX are written as addressed; no clamping.
- busy = (lane_mask != 0) | (state == WRITE) | pending full.

Test Plan:
- Feed pixels 0x11,0x22,0x33,0x44 at h=0..3, v=0, back-to-back with grant=1 -> one mem_we, addr 0x0000, data 0x44332211; pix_ready low for exactly one cycle.
- Feed h=508..511 at v=5 with values 0xA0..0xA3 -> addr {5,7'h7F}=0x02FF, data 0xA3A2A1A0; the next pixel h=0,v=6 goes to addr 0x0300.
- Feed h=4,5 (0x01,0x02), then h=12 (0x03) -> write of addr 0x0001 with data 0x00000201; pixel 0x03 is held in pending and lands in lane 0 at addr 0x0003.
- Word complete with mem_grant low for 10 cycles -> mem_we stays low, addr/data stable, pix_ready=0; the write occurs on the first granted edge.
- Full frame ending at (511,479) -> last write at addr 0xEFFF, then frame_done high for exactly 1 cycle, busy=0.
- Assert reset_n low while in WRITE with mem_grant=0 -> outputs go to reset values immediately (asynchronously); no write is issued after release.
